seq_restoring_divider: RTL and testbench

Multi-cycle unsigned restoring divider for the datapath labs. It is the inverse-operation partner to the team's gate-level array multiplier. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock, MSB first. It then presents quotient and remainder with a one-cycle done pulse. It sits beside the ALU as the DIV/MOD execution unit.

---
 rtl/seq_restoring_divider.sv | 134 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Quotient/remainder/div_by_zero are held until the next accepted start.
module seq_restoring_divider #(
  parameter int WIDTH = 8,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // DELAY annotates the clock-to-output time of the registers for timing
  // models; the RTL registers themselves are zero-delay.
  if (WIDTH < 2 || DELAY < 0) begin : g_param_check
    $error("seq_restoring_divider: WIDTH must be >= 2 and DELAY >= 0");
  end

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  // One restoring iteration. P stays below the divisor between iterations, so
  // only the shifted value and the trial difference need the extra bit.
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] q_d;
  logic             last_iter;

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    p_shift = {p_q, q_q[WIDTH-1]};
    trial   = p_shift - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      p_d = trial[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      p_d = p_shift[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  assign last_iter = (count_q == CW'(WIDTH - 1));

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the working registers are reset too; they are a handful of flops, not a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      divisor_q <= '0;
      p_q       <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              divisor_q <= divisor;
              p_q       <= '0;
              q_q       <= dividend;
              count_q   <= '0;
              dbz_q     <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_RUN;
            end else begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          p_q     <= p_d;
          q_q     <= q_d;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            quot_q  <= q_d;
            rem_q   <= p_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: a scoreboard queue holds the
// expected result of every accepted request and is popped on each done pulse.
module tb_seq_restoring_divider;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dbz;
  } result_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  result_t sb[$];
  int      n_checks = 0;
  int      n_fail = 0;

  seq_restoring_divider #(.WIDTH(W), .DELAY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    result_t r;
    if (b == '0) begin
      r.quot = '1;
      r.rem  = a;
      r.dbz  = 1'b1;
    end else begin
      r.quot = a / b;
      r.rem  = a % b;
      r.dbz  = 1'b0;
    end
    return r;
  endfunction

  // Presents one request for a single accepting edge and records its expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done at falling edges; lat counts edges after the accepting edge.
  task automatic wait_done(input int budget, output int lat, output int busy_cyc, output bit timeout);
    lat = 0;
    busy_cyc = 0;
    timeout = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cyc++;
      lat++;
      if (lat > budget) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  // Issues one operation and checks result, latency, busy time and pulse width.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int      lat, bc, exp_lat;
    bit      to;
    result_t exp;
    issue(a, b);
    wait_done(W + 4, lat, bc, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done within %0d cycles, need done", tag, W + 4);
      sb.delete();
      return;
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty: got done with no pending request, need none", tag);
      return;
    end
    exp = sb.pop_front();
    exp_lat = exp.dbz ? 0 : W;
    n_checks++;
    if (quotient !== exp.quot) begin
      n_fail++;
      $display("FAIL %s quotient: got %0d, need %0d", tag, quotient, exp.quot);
    end
    n_checks++;
    if (remainder !== exp.rem) begin
      n_fail++;
      $display("FAIL %s remainder: got %0d, need %0d", tag, remainder, exp.rem);
    end
    n_checks++;
    if (div_by_zero !== exp.dbz) begin
      n_fail++;
      $display("FAIL %s div_by_zero: got %b, need %b", tag, div_by_zero, exp.dbz);
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, need %0d", tag, lat, exp_lat);
    end
    n_checks++;
    if (bc != exp_lat || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: got %0d cycles (busy at done %b), need %0d cycles", tag, bc, busy, exp_lat);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || quotient !== exp.quot || remainder !== exp.rem) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b q=%0d r=%0d, need done=0 q=%0d r=%0d",
               tag, done, quotient, remainder, exp.quot, exp.rem);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, need all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b dbz=%b q=%0d r=%0d, need all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_basic();
    run_op(8'd100, 8'd7, "basic_100_7");
  endtask

  task automatic test_extremes();
    run_op(8'd255, 8'd1, "max_by_one");
    run_op(8'd5, 8'd9, "small_by_large");
    run_op(8'd0, 8'd255, "zero_dividend");
    run_op(8'd255, 8'd255, "equal_operands");
  endtask

  task automatic test_div_by_zero();
    run_op(8'd37, 8'd0, "div_by_zero_37");
    // A normal division afterwards must clear the flag.
    run_op(8'd50, 8'd5, "dbz_cleared");
  endtask

  task automatic test_start_ignored();
    int lat, bc, extra;
    bit to;
    result_t exp;
    issue(8'd200, 8'd3);
    repeat (2) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(W + 4, lat, bc, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL ignored_start done_timeout: got no done, need done");
      sb.delete();
      return;
    end
    exp = sb.pop_front();
    n_checks++;
    if (quotient !== exp.quot || remainder !== exp.rem || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start result: got q=%0d r=%0d dbz=%b, need q=%0d r=%0d dbz=0",
               quotient, remainder, div_by_zero, exp.quot, exp.rem);
    end
    extra = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignored_start queued: got %0d busy/done cycles afterwards, need 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int spurious;
    issue(8'd100, 8'd7);
    void'(sb.pop_back());
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got busy=%b done=%b dbz=%b q=%0d r=%0d, need all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL mid_run_reset no_done: got %0d busy/done cycles, need 0", spurious);
    end
    run_op(8'd100, 8'd7, "after_reset_100_7");
  endtask

  task automatic test_back_to_back();
    int      cyc, n_done, last_done;
    result_t exp;
    cyc = 0;
    n_done = 0;
    last_done = -1;
    dividend = 8'd9;
    divisor  = 8'd4;
    start    = 1'b1;
    repeat (3) sb.push_back(model(8'd9, 8'd4));
    while (n_done < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        exp = sb.pop_front();
        n_checks++;
        if (quotient !== exp.quot || remainder !== exp.rem) begin
          n_fail++;
          $display("FAIL back_to_back result %0d: got q=%0d r=%0d, need q=%0d r=%0d",
                   n_done, quotient, remainder, exp.quot, exp.rem);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done != W + 2) begin
            n_fail++;
            $display("FAIL back_to_back interval: got %0d, need %0d", cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        n_done++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 3) begin
      n_fail++;
      $display("FAIL back_to_back count: got %0d done pulses, need 3", n_done);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 20));
      run_op(a, b, $sformatf("random_%0d_%0d", a, b));
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending results, need 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
